// File: rtl/axil_ic_pkg.sv
// Shared AXI-Lite interconnect definitions, used by both the read and write address decoders.
package axil_ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HAND = 2'd1,
        RESP = 2'd2
    } axil_state_e;

endpackage

// File: rtl/axil_addr_match.sv
// Combinational region match with lowest-index priority; bit NUMBER_SLAVE flags a decode miss.
module axil_addr_match #(
    parameter int NUMBER_SLAVE = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)}
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [NUMBER_SLAVE:0]     hit
);

    logic [NUMBER_SLAVE-1:0] raw_hit;
    logic                    taken;

    // One extra bit on the upper bound keeps a region ending at the top of the map from wrapping to 0.
    always_comb begin
        raw_hit = '0;
        for (int i = 0; i < NUMBER_SLAVE; i++) begin
            raw_hit[i] = ({1'b0, addr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
                         ({1'b0, addr} <  ({1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]}));
        end
    end

    always_comb begin
        hit   = '0;
        taken = 1'b0;
        for (int i = 0; i < NUMBER_SLAVE; i++) begin
            if (raw_hit[i] && !taken) begin
                hit[i] = 1'b1;
                taken  = 1'b1;
            end
        end
        if (!taken) begin
            hit[NUMBER_SLAVE] = 1'b1;
        end
    end

endmodule

// File: rtl/axil_decoder_addr_wr.sv
// AXI-Lite write-path decoder: latches a one-hot route on AW and holds it until the B response.
// Optional response watchdog enabled by defining AXIL_DEC_WR_TIMEOUT_EN.
module axil_decoder_addr_wr
    import axil_ic_pkg::*;
#(
    parameter int NUMBER_SLAVE = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)},
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    input  logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic                      m_axil_bvalid,
    input  logic                      m_axil_bready,
    output logic [NUMBER_SLAVE:0]     slv_valid,
    output logic                      aw_open,
    output logic                      w_open,
    output logic                      timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    axil_state_e           state, state_nxt;
    logic [NUMBER_SLAVE:0] hit;
    logic [NUMBER_SLAVE:0] slv_nxt;
    logic                  aw_nxt, w_nxt;
    logic                  aw_hs, w_hs, b_hs;
    logic                  wd_expire;

    axil_addr_match #(
        .NUMBER_SLAVE   (NUMBER_SLAVE),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_ADDR_OFFSET(AXI_ADDR_OFFSET),
        .AXI_ADDR_RANGE (AXI_ADDR_RANGE)
    ) u_match (
        .addr(addr),
        .hit (hit)
    );

    assign aw_hs = aw_open && m_axil_awvalid && m_axil_awready;
    assign w_hs  = w_open && m_axil_wvalid && m_axil_wready;
    assign b_hs  = m_axil_bvalid && m_axil_bready;

    // Route is captured only from IDLE, so addr changes during HAND/RESP never disturb it.
    always_comb begin
        state_nxt = state;
        slv_nxt   = slv_valid;
        aw_nxt    = aw_open;
        w_nxt     = w_open;
        case (state)
            IDLE: begin
                if (m_axil_awvalid) begin
                    state_nxt = HAND;
                    slv_nxt   = hit;
                    aw_nxt    = 1'b1;
                    w_nxt     = 1'b1;
                end
            end
            HAND: begin
                if (aw_hs) aw_nxt = 1'b0;
                if (w_hs)  w_nxt  = 1'b0;
                if (!aw_nxt && !w_nxt) state_nxt = RESP;
            end
            RESP: begin
                if (b_hs || wd_expire) begin
                    state_nxt = IDLE;
                    slv_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                slv_nxt   = '0;
                aw_nxt    = 1'b0;
                w_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            slv_valid <= '0;
            aw_open   <= 1'b0;
            w_open    <= 1'b0;
        end else begin
            state     <= state_nxt;
            slv_valid <= slv_nxt;
            aw_open   <= aw_nxt;
            w_open    <= w_nxt;
        end
    end

`ifdef AXIL_DEC_WR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counts RESP cycles; leaving RESP (or never entering it) holds the count at zero.
    always_ff @(posedge aclk) begin
        if (areset || state != RESP) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expire = (state == RESP) && (wd_cnt == CNT_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    // A B handshake arriving in the expiry cycle wins; no abort is signalled then.
    assign timeout = wd_expire && !b_hs;

endmodule

// File: doc/axil_decoder_addr_wr.md
AXIL_DECODER_ADDR_WR -- requirements
Module: axil_decoder_addr_wr

Interface
REQ-001 SHALL have parameter NUMBER_SLAVE, default 4: number of decoded slave ports.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32: write-address width.
REQ-003 SHALL have parameter AXI_ADDR_OFFSET[NUMBER_SLAVE], default all 0: base address per slave.
REQ-004 SHALL have parameter AXI_ADDR_RANGE[NUMBER_SLAVE], default all 1: region size per slave in bytes.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: response watchdog limit, used only with the macro in REQ-024.
REQ-006 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port addr, input, AXI_ADDR_WIDTH bits: the master's AWADDR.
REQ-009 SHALL have port m_axil_awvalid / m_axil_awready, inputs, 1 bit each: the AW handshake.
REQ-010 SHALL have port m_axil_wvalid / m_axil_wready, inputs, 1 bit each: the W handshake.
REQ-011 SHALL have port m_axil_bvalid / m_axil_bready, inputs, 1 bit each: the B handshake.
REQ-012 SHALL have port slv_valid, output, NUMBER_SLAVE+1 bits: one-hot route select; bit NUMBER_SLAVE is the decode-error slot.
REQ-013 SHALL have ports aw_open / w_open, outputs, 1 bit each: high while the AW / W handshake of the current transaction is still outstanding.
REQ-014 SHALL have port timeout, output, 1 bit: one-cycle pulse when the watchdog aborts a transaction.

Function
REQ-015 SHALL implement FSM states IDLE, HAND and RESP.
REQ-016 In IDLE with m_axil_awvalid=1, SHALL latch the decode of addr into slv_valid, set aw_open=w_open=1 and go to HAND on the next edge; with awvalid=0, SHALL stay in IDLE with slv_valid=0.
REQ-017 SHALL decode hit[i] = (addr >= OFFSET[i]) && (addr < OFFSET[i]+RANGE[i]), computing the sum at AXI_ADDR_WIDTH+1 bits so the top region never wraps.
REQ-018 On multiple hits, SHALL select only the lowest index; with no hit, SHALL set only bit NUMBER_SLAVE; slv_valid SHALL be exactly one-hot whenever it is non-zero.
REQ-019 In HAND, SHALL clear aw_open on the cycle after awvalid&&awready and clear w_open on the cycle after wvalid&&wready; both may complete in the same cycle, and W may complete before AW.
REQ-020 SHALL go from HAND to RESP on the edge where the last outstanding AW/W handshake completes, including the case where both complete in the same cycle.
REQ-021 SHALL ignore a B handshake seen outside RESP, with no state change.
REQ-022 In RESP, on bvalid&&bready, SHALL clear slv_valid and return to IDLE; a new AW SHALL NOT be accepted in that same cycle, so the minimum gap is one IDLE cycle.
REQ-023 SHALL hold slv_valid stable from HAND entry until RESP exit, regardless of changes on addr.

Configuration
REQ-024 With macro AXIL_DEC_WR_TIMEOUT_EN defined, SHALL count consecutive RESP cycles without a B handshake (count starts at 0 on RESP entry); when the count reaches TIMEOUT_CYCLES-1, SHALL pulse timeout for one cycle, clear slv_valid and return to IDLE.
REQ-025 Without AXIL_DEC_WR_TIMEOUT_EN, SHALL contain no counter, tie timeout to 0 and wait in RESP indefinitely.

Reset
REQ-026 While areset=1 at a clock edge, SHALL force state=IDLE, slv_valid=0, aw_open=0, w_open=0, timeout=0 and watchdog count=0, including mid-transaction in HAND or RESP.
REQ-027 SHALL treat the first cycle after areset deasserts as IDLE; an awvalid in that cycle SHALL be accepted.

Structure
REQ-028 SHALL take the state enum (IDLE, HAND, RESP) from shared package axil_ic_pkg, which the read-path decoder also uses.
REQ-029 SHALL implement the combinational range match and priority one-hot in sub-module axil_addr_match (parameters as REQ-001..004; in addr; out hit[NUMBER_SLAVE:0]), shared with the read path.

Verification
REQ-030 Bench SHALL check: OFFSET={0x0,0x1000,0x2000,0x3000}, RANGE=0x1000, AW to 0x1004 with AW and W in the same cycle -> slv_valid=5'b00010 next cycle, HAND->RESP one edge later, cleared one cycle after the B handshake.
REQ-031 Bench SHALL check: W handshake 3 cycles before AW handshake, addr 0x2FFC -> slv_valid=5'b00100, w_open falls before aw_open, RESP entered only after AW.
REQ-032 Bench SHALL check: addr 0x8000 -> slv_valid=5'b10000 (error slot); overlapping regions OFFSET[1]=OFFSET[2]=0x1000 with addr 0x1000 -> 5'b00010.
REQ-033 Bench SHALL check: OFFSET[3]=0xFFFFF000, RANGE[3]=0x1000, addr 0xFFFFFFFC -> bit 3 set, with no wrap miss.
REQ-034 Bench SHALL check: areset=1 asserted in RESP -> all outputs 0 at the next edge; awvalid in the first cycle after release is accepted.
REQ-035 Bench SHALL check, with AXIL_DEC_WR_TIMEOUT_EN and TIMEOUT_CYCLES=8, no bvalid -> timeout pulses in the 8th RESP cycle, then IDLE with slv_valid=0; without the macro, timeout stays 0 throughout.
